// File: rtl/sdram_encode_if.sv
// Encoder-side bundle: SDRAM read-FIFO pop port, UART TX start/busy pair, status flags.
// Master is the framer; slave is the FIFO/UART environment around it.
interface sdram_encode_if;
    logic       rd_done;
    logic       rfifo_empty;
    logic [7:0] rfifo_rd_data;
    logic       rfifo_rd_en;
    logic       tx_busy;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       enc_busy;
    logic       ovr_err;

    modport master (
        input  rd_done,
        input  rfifo_empty,
        input  rfifo_rd_data,
        input  tx_busy,
        output rfifo_rd_en,
        output tx_trig,
        output tx_data,
        output enc_busy,
        output ovr_err
    );

    modport slave (
        output rd_done,
        output rfifo_empty,
        output rfifo_rd_data,
        output tx_busy,
        input  rfifo_rd_en,
        input  tx_trig,
        input  tx_data,
        input  enc_busy,
        input  ovr_err
    );
endinterface

// File: rtl/sdram_encode.sv
// Frames each SDRAM read burst as HEADER + BURST_LEN FIFO bytes towards the UART TX.
// Latency: rd_done -> header tx_trig next cycle; 3 cycles per data byte beyond UART time.
// Backpressure: holds on tx_busy before each trigger and stalls without popping on rfifo_empty.
module sdram_encode #(
    parameter int         BURST_LEN = 4,
    parameter logic [7:0] HEADER    = 8'haa
) (
    input  logic          s_clk,
    input  logic          s_rst,
    sdram_encode_if.master enc
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        FETCH,
        LATCH
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BURST_LEN);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tx_data_q;
    logic [3:0] byte_cnt;
    logic       pend;
    logic       ovr_err_q;
    logic       tx_trig_c;
    logic       rd_en_c;
    logic       frame_start;

    assign frame_start = (state == IDLE) && (enc.rd_done || pend);

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are gated by the same condition that advances the state, so each fires once per visit.
    always_comb begin
        state_nxt = state;
        tx_trig_c = 1'b0;
        rd_en_c   = 1'b0;
        case (state)
            IDLE: begin
                if (enc.rd_done || pend) state_nxt = SEND;
            end
            SEND: begin
                if (!enc.tx_busy) begin
                    tx_trig_c = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (enc.tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!enc.tx_busy) state_nxt = (byte_cnt == LAST_CNT) ? IDLE : FETCH;
            end
            FETCH: begin
                if (!enc.rfifo_empty) begin
                    rd_en_c   = 1'b1;
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                state_nxt = SEND;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            tx_data_q <= 8'h00;
            byte_cnt  <= 4'd0;
            pend      <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            if (frame_start) begin
                tx_data_q <= HEADER;
                byte_cnt  <= 4'd0;
            end
            if (state == LATCH) begin
                tx_data_q <= enc.rfifo_rd_data;
                byte_cnt  <= byte_cnt + 4'd1;
            end
            // In IDLE a pending request is consumed unless a fresh rd_done arrives alongside it.
            if (state == IDLE) begin
                pend <= pend & enc.rd_done;
            end else if (enc.rd_done) begin
                if (!pend) pend <= 1'b1;
                else       ovr_err_q <= 1'b1;
            end
        end
    end

    assign enc.tx_trig     = tx_trig_c;
    assign enc.rfifo_rd_en = rd_en_c;
    assign enc.tx_data     = tx_data_q;
    assign enc.enc_busy    = (state != IDLE);
    assign enc.ovr_err     = ovr_err_q;

endmodule

// File: tb/tb_sdram_encode.sv
// Directed bench for sdram_encode: table of frames plus reset, busy-hold, pending/overrun sequences.
module tb_sdram_encode;

    typedef struct packed {
        logic [3:0][7:0] dat;
        logic [7:0]      ulen;
        logic [7:0]      delay;
        logic [4:0][7:0] exp;
    } vec_t;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;

    sdram_encode_if ifc ();

    sdram_encode #(.BURST_LEN(4), .HEADER(8'haa)) dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .enc   (ifc)
    );

    always #5 s_clk = ~s_clk;

    int         cyc = 0;
    logic       mon_trig = 1'b0;
    logic       mon_rd_en = 1'b0;
    int         trig_cnt = 0;
    int         pop_cnt = 0;
    int         bad_cnt = 0;
    int         enc_fall_cyc = 0;
    logic       prev_enc = 1'b0;
    logic [7:0] cap[$];
    int         trig_cyc[$];
    logic       uart_busy = 1'b0;
    logic       force_busy = 1'b0;
    int         ucnt = 0;
    int         uart_len = 4;
    logic [7:0] fmem[0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] rd_data_r = 8'd0;
    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       tbl[4];

    assign ifc.tx_busy       = uart_busy | force_busy;
    assign ifc.rfifo_empty   = (wr_ptr == rd_ptr);
    assign ifc.rfifo_rd_data = rd_data_r;

    // Output monitor, sampled mid-cycle.
    initial forever begin
        @(negedge s_clk);
        mon_trig  = ifc.tx_trig;
        mon_rd_en = ifc.rfifo_rd_en;
        if (ifc.tx_trig) begin
            cap.push_back(ifc.tx_data);
            trig_cyc.push_back(cyc);
            trig_cnt++;
        end
        if (ifc.rfifo_rd_en) begin
            pop_cnt++;
            if (ifc.rfifo_empty) bad_cnt++;
        end
        if (prev_enc && !ifc.enc_busy) enc_fall_cyc = cyc;
        prev_enc = ifc.enc_busy;
    end

    // UART busy for uart_len cycles starting the cycle after tx_trig; FIFO registered read.
    initial forever begin
        @(posedge s_clk);
        cyc++;
        #1;
        if (mon_trig) begin
            uart_busy = 1'b1;
            ucnt      = uart_len;
        end else if (uart_busy) begin
            ucnt--;
            if (ucnt <= 0) uart_busy = 1'b0;
        end
        if (mon_rd_en) begin
            rd_data_r = fmem[rd_ptr];
            rd_ptr++;
        end
    end

    task automatic tick();
        @(posedge s_clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic pulse_rd_done(output int c);
        tick();
        ifc.rd_done = 1'b1;
        c = cyc;
        tick();
        ifc.rd_done = 1'b0;
    endtask

    task automatic wait_trigs(input int n, input string nm);
        for (int i = 0; i < 3000 && trig_cnt < n; i++) tick();
        check(nm, 32'(trig_cnt >= n), 1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 3000 && (ifc.enc_busy || ifc.tx_busy); i++) tick();
        check(nm, 32'(ifc.enc_busy || ifc.tx_busy), 0);
    endtask

    function automatic vec_t mk(input logic [7:0] d0, d1, d2, d3, ul, dl,
                                input logic [7:0] e0, e1, e2, e3, e4);
        vec_t v;
        v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
        v.ulen = ul;
        v.delay = dl;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input string nm);
        int b, p, bad, x, n;
        b = trig_cnt;
        p = pop_cnt;
        bad = bad_cnt;
        uart_len = int'(v.ulen);
        n = uart_len;
        if (v.delay == 8'd0) for (int i = 0; i < 4; i++) push(v.dat[i]);
        pulse_rd_done(x);
        if (v.delay != 8'd0) begin
            repeat (int'(v.delay)) tick();
            check({nm, "_stall_trigs"}, trig_cnt - b, 1);
            check({nm, "_stall_pops"}, pop_cnt - p, 0);
            for (int i = 0; i < 4; i++) push(v.dat[i]);
        end
        wait_trigs(b + 5, {nm, "_trig_timeout"});
        wait_idle({nm, "_idle_timeout"});
        repeat (5) tick();
        for (int i = 0; i < 5; i++) check({nm, "_byte"}, 32'(cap[b + i]), 32'(v.exp[i]));
        check({nm, "_trig_count"}, trig_cnt - b, 5);
        check({nm, "_pop_count"}, pop_cnt - p, 4);
        check({nm, "_pop_when_empty"}, bad_cnt - bad, 0);
        check({nm, "_hdr_latency"}, trig_cyc[b] - x, 1);
        check({nm, "_enc_busy_fall"}, enc_fall_cyc - trig_cyc[b + 4], n + 2);
        if (v.delay == 8'd0) check({nm, "_byte_gap"}, trig_cyc[b + 2] - trig_cyc[b + 1], n + 4);
    endtask

    initial begin
        int b, p, x, r;
        ifc.rd_done = 1'b0;
        tbl[0] = mk(8'h11, 8'h22, 8'h33, 8'h44, 8'd10, 8'd0,  8'haa, 8'h11, 8'h22, 8'h33, 8'h44);
        tbl[1] = mk(8'h50, 8'h51, 8'h52, 8'h53, 8'd6,  8'd50, 8'haa, 8'h50, 8'h51, 8'h52, 8'h53);
        tbl[2] = mk(8'h00, 8'hff, 8'h80, 8'h7f, 8'd2,  8'd0,  8'haa, 8'h00, 8'hff, 8'h80, 8'h7f);
        tbl[3] = mk(8'h71, 8'h72, 8'h73, 8'h74, 8'd1,  8'd0,  8'haa, 8'h71, 8'h72, 8'h73, 8'h74);

        // Reset values, then asynchronous reset in the middle of a header send.
        repeat (3) tick();
        check("rst_tx_trig", 32'(ifc.tx_trig), 0);
        check("rst_rd_en", 32'(ifc.rfifo_rd_en), 0);
        check("rst_enc_busy", 32'(ifc.enc_busy), 0);
        check("rst_ovr_err", 32'(ifc.ovr_err), 0);
        check("rst_tx_data", 32'(ifc.tx_data), 0);
        s_rst = 1'b0;
        repeat (10) tick();
        check("idle_no_trig", trig_cnt, 0);
        pulse_rd_done(x);
        check("pre_rst_trig", 32'(ifc.tx_trig), 1);
        check("pre_rst_hdr", 32'(ifc.tx_data), 32'h aa);
        s_rst = 1'b1;
        #1;
        check("async_rst_trig", 32'(ifc.tx_trig), 0);
        check("async_rst_data", 32'(ifc.tx_data), 0);
        check("async_rst_busy", 32'(ifc.enc_busy), 0);
        tick();
        tick();
        s_rst = 1'b0;
        repeat (10) tick();
        check("post_rst_no_trig", trig_cnt, 0);

        // Table-driven frames, including the empty-FIFO stall row.
        for (int i = 0; i < 3; i++) run_frame(tbl[i], $sformatf("row%0d", i));

        // TX busy held before the frame starts.
        b = trig_cnt;
        uart_len = 3;
        for (int i = 0; i < 4; i++) push(8'hc1 + 8'(i));
        force_busy = 1'b1;
        pulse_rd_done(x);
        repeat (20) tick();
        check("busy_hold_trigs", trig_cnt - b, 0);
        force_busy = 1'b0;
        r = cyc;
        wait_trigs(b + 1, "busy_rel_timeout");
        check("busy_rel_cycle", trig_cyc[b] - r, 0);
        check("busy_rel_hdr", 32'(cap[b]), 32'haa);
        wait_trigs(b + 5, "busy_frame_timeout");
        wait_idle("busy_idle_timeout");
        check("busy_second_trig", trig_cyc[b + 1] - r, 7);
        check("busy_trig_count", trig_cnt - b, 5);
        check("busy_last_byte", 32'(cap[b + 4]), 32'hc4);

        // Pending frame and overrun.
        b = trig_cnt;
        p = pop_cnt;
        uart_len = 4;
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("ovr_clear_before", 32'(ifc.ovr_err), 0);
        pulse_rd_done(x);
        wait_trigs(b + 2, "pend_f1_timeout");
        pulse_rd_done(x);
        check("ovr_after_pend", 32'(ifc.ovr_err), 0);
        repeat (3) tick();
        pulse_rd_done(x);
        tick();
        check("ovr_set", 32'(ifc.ovr_err), 1);
        wait_trigs(b + 10, "pend_f2_timeout");
        wait_idle("pend_idle_timeout");
        repeat (30) tick();
        check("pend_trig_count", trig_cnt - b, 10);
        check("pend_pop_count", pop_cnt - p, 8);
        check("pend_f2_hdr", 32'(cap[b + 5]), 32'haa);
        check("pend_f2_first", 32'(cap[b + 6]), 32'h05);
        check("pend_f2_last", 32'(cap[b + 9]), 32'h08);
        check("pend_f2_gap", trig_cyc[b + 5] - trig_cyc[b + 4], 4 + 3);
        check("ovr_sticky", 32'(ifc.ovr_err), 1);

        // Reset in the middle of a frame, then a fresh frame.
        b = trig_cnt;
        p = pop_cnt;
        uart_len = 5;
        push(8'h61);
        push(8'h62);
        pulse_rd_done(x);
        wait_trigs(b + 3, "mid_rst_timeout");
        repeat (2) tick();
        s_rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(ifc.enc_busy), 0);
        check("mid_rst_ovr", 32'(ifc.ovr_err), 0);
        check("mid_rst_data", 32'(ifc.tx_data), 0);
        tick();
        tick();
        s_rst = 1'b0;
        wait_idle("mid_rst_drain");
        check("mid_rst_trigs", trig_cnt - b, 3);
        check("mid_rst_pops", pop_cnt - p, 2);
        run_frame(tbl[3], "row3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
